// File: rtl/jk_pkg.sv
// JK flag bank shared definitions: command encoding and the per-bit next-state helper.
package jk_pkg;

  localparam int unsigned JK_CMD_W = 2;

  typedef logic [JK_CMD_W-1:0] jk_cmd_t;

  localparam jk_cmd_t JK_HOLD   = 2'b00;
  localparam jk_cmd_t JK_RESET  = 2'b01;
  localparam jk_cmd_t JK_SET    = 2'b10;
  localparam jk_cmd_t JK_TOGGLE = 2'b11;

  // Next value of one JK bit for a given {j,k} command and current state.
  function automatic logic jk_next(input jk_cmd_t cmd, input logic q);
    logic nxt;
    nxt = q;
    case (cmd)
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with parallel load and global enable.
// Exposes its combinational next state so the parent can derive edge pulses
// and change detection without a second register stage.
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  input  logic load_val,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_nxt_c
);

  // Next state: load beats enable; disabled cell holds.
  always_comb begin
    q_nxt_c = q;
    if (load) begin
      q_nxt_c = load_val;
    end else if (en) begin
      q_nxt_c = jk_next(jk_cmd_t'({j, k}), q);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= q_nxt_c;
    end
  end

endmodule : jk_cell

// File: rtl/jk_ff_bank.sv
// WIDTH-channel JK flag bank with parallel load, registered rise/fall pulses
// and a saturating count of edges on which any flag changed.
// Optional: define JK_FF_BANK_PARITY_EN to add q_par, the registered parity of q.
module jk_ff_bank
  import jk_pkg::*;
#(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}},
  parameter int unsigned       CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             chg_cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic [CNT_W-1:0] chg_cnt
`ifdef JK_FF_BANK_PARITY_EN
  ,
  output logic             q_par
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_nxt;
  logic             any_chg;

  // One JK cell per channel.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RST_VAL (RST_VAL[i])
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .load     (load),
      .load_val (load_val[i]),
      .j        (j[i]),
      .k        (k[i]),
      .q        (q[i]),
      .q_nxt_c  (q_nxt[i])
    );
  end

  // Any channel about to change on this edge; many bits still count once.
  always_comb begin
    any_chg = 1'b0;
    any_chg = (q_nxt != q);
  end

  // Edge pulses registered alongside q so they line up with the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_rise <= '0;
      q_fall <= '0;
    end else begin
      q_rise <= q_nxt & ~q;
      q_fall <= ~q_nxt & q;
    end
  end

  // Saturating change counter; clear wins over a same-edge change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_cnt <= '0;
    end else if (chg_cnt_clr) begin
      chg_cnt <= '0;
    end else if (any_chg && (chg_cnt != CNT_MAX)) begin
      chg_cnt <= chg_cnt + CNT_W'(1);
    end
  end

`ifdef JK_FF_BANK_PARITY_EN
  // Parity of the next state, so it matches ^q in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_par <= ^RST_VAL;
    end else begin
      q_par <= ^q_nxt;
    end
  end
`endif

endmodule : jk_ff_bank

// File: tb/tb_jk_ff_bank.sv
// Directed, table-driven bench for jk_ff_bank (WIDTH=4, RST_VAL=0101, CNT_W=3).
module tb_jk_ff_bank;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;
  localparam logic [WIDTH-1:0] RST_VAL = 4'b0101;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             chg_cnt_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_rise;
  logic [WIDTH-1:0] q_fall;
  logic [CNT_W-1:0] chg_cnt;
`ifdef JK_FF_BANK_PARITY_EN
  logic             q_par;
`endif

  int checks;
  int failures;

  typedef struct {
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             clr;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_rise;
    logic [WIDTH-1:0] exp_fall;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  jk_ff_bank #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .j           (j),
    .k           (k),
    .chg_cnt_clr (chg_cnt_clr),
    .q           (q),
    .q_rise      (q_rise),
    .q_fall      (q_fall),
    .chg_cnt     (chg_cnt)
`ifdef JK_FF_BANK_PARITY_EN
    ,
    .q_par       (q_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [WIDTH-1:0] eq,
                           input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] ef,
                           input logic [CNT_W-1:0] ec);
    check({tag, "_q"}, 32'(q), 32'(eq));
    check({tag, "_rise"}, 32'(q_rise), 32'(er));
    check({tag, "_fall"}, 32'(q_fall), 32'(ef));
    check({tag, "_cnt"}, 32'(chg_cnt), 32'(ec));
`ifdef JK_FF_BANK_PARITY_EN
    check({tag, "_par"}, 32'(q_par), 32'(^eq));
`endif
  endtask

  task automatic add(input logic ld, input logic [WIDTH-1:0] lv, input logic e,
                     input logic [WIDTH-1:0] jj, input logic [WIDTH-1:0] kk, input logic c,
                     input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                     input logic [WIDTH-1:0] ef, input logic [CNT_W-1:0] ec);
    vec_t v;
    v.load = ld; v.load_val = lv; v.en = e; v.j = jj; v.k = kk; v.clr = c;
    v.exp_q = eq; v.exp_rise = er; v.exp_fall = ef; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    en = 1'b0; load = 1'b0; load_val = '0; j = '0; k = '0; chg_cnt_clr = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle_inputs();

    //   ld lv       en j        k        clr  q        rise     fall     cnt
    add(0, 4'b0000, 0, 4'b1111, 4'b1111, 0, 4'b0101, 4'b0000, 4'b0000, 3'd0);
    add(0, 4'b0000, 1, 4'b1010, 4'b0101, 0, 4'b1010, 4'b1010, 4'b0101, 3'd1);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 4'b1010, 4'b0000, 4'b0000, 3'd1);
    // nine toggles: counter saturates at 7
    add(0, 4'b0000, 1, 4'b1111, 4'b1111, 0, 4'b0101, 4'b0101, 4'b1010, 3'd2);
    add(0, 4'b0000, 1, 4'b1111, 4'b1111, 0, 4'b1010, 4'b1010, 4'b0101, 3'd3);
    add(0, 4'b0000, 1, 4'b1111, 4'b1111, 0, 4'b0101, 4'b0101, 4'b1010, 3'd4);
    add(0, 4'b0000, 1, 4'b1111, 4'b1111, 0, 4'b1010, 4'b1010, 4'b0101, 3'd5);
    add(0, 4'b0000, 1, 4'b1111, 4'b1111, 0, 4'b0101, 4'b0101, 4'b1010, 3'd6);
    add(0, 4'b0000, 1, 4'b1111, 4'b1111, 0, 4'b1010, 4'b1010, 4'b0101, 3'd7);
    add(0, 4'b0000, 1, 4'b1111, 4'b1111, 0, 4'b0101, 4'b0101, 4'b1010, 3'd7);
    add(0, 4'b0000, 1, 4'b1111, 4'b1111, 0, 4'b1010, 4'b1010, 4'b0101, 3'd7);
    add(0, 4'b0000, 1, 4'b1111, 4'b1111, 0, 4'b0101, 4'b0101, 4'b1010, 3'd7);
    // load wins over enable; reloading the same value is not a change
    add(1, 4'b0011, 1, 4'b1111, 4'b1111, 0, 4'b0011, 4'b0010, 4'b0100, 3'd7);
    add(1, 4'b0011, 1, 4'b1111, 4'b1111, 0, 4'b0011, 4'b0000, 4'b0000, 3'd7);
    // clear on a toggle edge, then count resumes
    add(0, 4'b0000, 1, 4'b1111, 4'b1111, 1, 4'b1100, 4'b1100, 4'b0011, 3'd0);
    add(0, 4'b0000, 1, 4'b1111, 4'b1111, 0, 4'b0011, 4'b0011, 4'b1100, 3'd1);
    // per-bit commands: hold, set, reset, toggle
    add(0, 4'b0000, 1, 4'b0101, 4'b0011, 0, 4'b0100, 4'b0100, 4'b0011, 3'd2);
    add(0, 4'b0000, 0, 4'b1111, 4'b1111, 1, 4'b0100, 4'b0000, 4'b0000, 3'd0);
    // parity walk 0000, 0001, 0011, 0111
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0100, 3'd1);
    add(1, 4'b0001, 0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000, 3'd2);
    add(1, 4'b0011, 0, 4'b0000, 4'b0000, 0, 4'b0011, 4'b0010, 4'b0000, 3'd3);
    add(1, 4'b0111, 0, 4'b0000, 4'b0000, 0, 4'b0111, 4'b0100, 4'b0000, 3'd4);

    // Reset held across edges.
    repeat (2) @(negedge clk);
    check_all("reset", RST_VAL, 4'b0000, 4'b0000, 3'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      load = vecs[i].load; load_val = vecs[i].load_val; en = vecs[i].en;
      j = vecs[i].j; k = vecs[i].k; chg_cnt_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].exp_q, vecs[i].exp_rise,
                vecs[i].exp_fall, vecs[i].exp_cnt);
    end

    // Mid-cycle async reset with a rise pulse in flight: no clock edge needed.
    #2;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_all("async_rst", RST_VAL, 4'b0000, 4'b0000, 3'd0);
    @(posedge clk);
    #1;
    check_all("rst_hold", RST_VAL, 4'b0000, 4'b0000, 3'd0);

    // Release, then a toggle edge counts from zero.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst_idle", RST_VAL, 4'b0000, 4'b0000, 3'd0);
    @(negedge clk);
    en = 1'b1; j = 4'b1111; k = 4'b1111;
    @(posedge clk);
    #1;
    check_all("post_rst_tgl", 4'b1010, 4'b1010, 4'b0101, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_jk_ff_bank
